// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole game sequencer and its consumers.
// Holds the state encoding, hole/miss widths, flash length and LFSR taps.
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_UP   = 3'd2,
        ST_HIT  = 3'd3,
        ST_OVER = 3'd4
    } state_e;

    localparam int HOLE_W           = 4;
    localparam int MISS_W           = 4;
    localparam int HIT_FLASH_CYCLES = 8;

    // Taps 8,6,5,4 of a shift-left Fibonacci LFSR (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_game_ctrl_lfsr.sv
// Free-running 8-bit LFSR used to pick the next mole hole.
// Ports: clk, rst (async high), seed_i (reset value), value_o (current state).
module mole_lfsr
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed_i,
    output logic [7:0] value_o
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= seed_i;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: picks mole holes, times visibility, qualifies
// hits against the hammer position and keeps score/miss counts.
// Ports: clk, rst (async high), start, hit, hammer_pos in;
//        mole_active, mole_idx, hit_flash, score, misses, game_over out.
// Optional feature: define SPEEDUP_EN to shorten the UP window as score grows.
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int         NUM_HOLES  = 9,
    parameter int         GAP_CYCLES = 25_000_000,
    parameter int         UP_CYCLES  = 50_000_000,
    parameter int         MAX_MISSES = 3,
    parameter int         SCORE_W    = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit,
    input  logic [HOLE_W-1:0]  hammer_pos,
    output logic               mole_active,
    output logic [HOLE_W-1:0]  mole_idx,
    output logic               hit_flash,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               game_over
);

    localparam int T_RAW = (GAP_CYCLES > UP_CYCLES) ? GAP_CYCLES : UP_CYCLES;
    localparam int T_MAX = (T_RAW > HIT_FLASH_CYCLES) ? T_RAW : HIT_FLASH_CYCLES;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0]      GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]      HIT_LAST  = TW'(HIT_FLASH_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [MISS_W-1:0]  MISS_LIM  = MISS_W'(MAX_MISSES);

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                hit_q;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [MISS_W-1:0]   misses_q, misses_d;
    logic [HOLE_W-1:0]   idx_q, idx_d;
    logic                mole_active_q, hit_flash_q, game_over_q;
    logic [7:0]          lfsr;
    logic [TW-1:0]       up_lim;

    logic                hit_edge, valid_hit, start_game;
    logic                gap_done, up_done, hit_done;
    logic [MISS_W-1:0]   miss_inc;
    logic [SCORE_W-1:0]  score_inc;
    logic [HOLE_W-1:0]   pick_raw, pick;

    mole_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .seed_i  (LFSR_SEED),
        .value_o (lfsr)
    );

    assign hit_edge   = hit & ~hit_q;
    assign valid_hit  = hit_edge
                      & ({1'b0, hammer_pos} < 5'(NUM_HOLES))
                      & (hammer_pos == idx_q);
    assign start_game = start & ((state_q == ST_IDLE) | (state_q == ST_OVER));
    assign gap_done   = (timer_q == GAP_LAST);
    assign up_done    = (timer_q == up_lim - TW'(1));
    assign hit_done   = (timer_q == HIT_LAST);
    assign miss_inc   = misses_q + MISS_W'(1);
    assign score_inc  = score_q + SCORE_W'(1);

    // Never repeat the previous hole: bump to the next one, wrapping.
    assign pick_raw = HOLE_W'(lfsr % 8'(NUM_HOLES));
    assign pick     = (pick_raw != idx_q)                    ? pick_raw :
                      (pick_raw == HOLE_W'(NUM_HOLES - 1))   ? '0 :
                                                               pick_raw + HOLE_W'(1);

`ifdef SPEEDUP_EN
    localparam logic [TW-1:0] LIM_START = TW'(UP_CYCLES);
    localparam logic [TW-1:0] LIM_STEP  = TW'(UP_CYCLES / 8);
    localparam logic [TW-1:0] LIM_FLOOR = TW'(UP_CYCLES / 4);

    logic [TW-1:0] up_lim_q, up_lim_d;

    always_comb begin
        up_lim_d = up_lim_q;
        if (start_game) begin
            up_lim_d = LIM_START;
        end else if (state_q == ST_UP && valid_hit && score_q != SCORE_MAX
                     && (32'(score_inc) % 4) == 0) begin
            up_lim_d = (up_lim_q >= LIM_FLOOR + LIM_STEP) ?
                       up_lim_q - LIM_STEP : LIM_FLOOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_lim_q <= LIM_START;
        end else begin
            up_lim_q <= up_lim_d;
        end
    end

    assign up_lim = up_lim_q;
`else
    assign up_lim = TW'(UP_CYCLES);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_done) state_d = ST_UP;
            end
            ST_UP: begin
                // A hit wins over a timeout landing on the same cycle.
                if (valid_hit) begin
                    state_d = ST_HIT;
                end else if (up_done) begin
                    state_d = (miss_inc == MISS_LIM) ? ST_OVER : ST_GAP;
                end
            end
            ST_HIT: begin
                if (hit_done) state_d = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_d  = timer_q + TW'(1);
        score_d  = score_q;
        misses_d = misses_q;
        idx_d    = idx_q;
        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_OVER) begin
            timer_d = '0;
        end
        if (start_game) begin
            score_d  = '0;
            misses_d = '0;
        end
        if (state_q == ST_GAP && gap_done) begin
            idx_d = pick;
        end
        if (state_q == ST_UP) begin
            if (valid_hit) begin
                if (score_q != SCORE_MAX) score_d = score_inc;
            end else if (up_done) begin
                misses_d = miss_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q       <= '0;
            hit_q         <= 1'b0;
            score_q       <= '0;
            misses_q      <= '0;
            idx_q         <= '0;
            mole_active_q <= 1'b0;
            hit_flash_q   <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            hit_q         <= hit;
            score_q       <= score_d;
            misses_q      <= misses_d;
            idx_q         <= idx_d;
            mole_active_q <= (state_d == ST_UP);
            hit_flash_q   <= (state_d == ST_HIT);
            game_over_q   <= (state_d == ST_OVER);
        end
    end

    assign mole_active = mole_active_q;
    assign mole_idx    = idx_q;
    assign hit_flash   = hit_flash_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl with a phase/countdown game model.
// Small timing parameters; score width 3 so saturation is reachable.
module tb_mole_game_ctrl;

    localparam int NH   = 9;
    localparam int GAP  = 5;
    localparam int UP   = 10;
    localparam int MAXM = 3;
    localparam int SW   = 3;
    localparam int SMAX = (1 << SW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_GAP  = 1;
    localparam int P_UP   = 2;
    localparam int P_HIT  = 3;
    localparam int P_OVER = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          hit = 1'b0;
    logic [3:0]    hammer_pos = 4'd0;
    logic          mole_active;
    logic [3:0]    mole_idx;
    logic          hit_flash;
    logic [SW-1:0] score;
    logic [3:0]    misses;
    logic          game_over;

    int vecs = 0;
    int errs = 0;

    mole_game_ctrl #(
        .NUM_HOLES  (NH),
        .GAP_CYCLES (GAP),
        .UP_CYCLES  (UP),
        .MAX_MISSES (MAXM),
        .SCORE_W    (SW),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hit         (hit),
        .hammer_pos  (hammer_pos),
        .mole_active (mole_active),
        .mole_idx    (mole_idx),
        .hit_flash   (hit_flash),
        .score       (score),
        .misses      (misses),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Reference model: game phase plus cycles remaining in that phase.
    int       m_ph, m_left, m_score, m_miss, m_idx, m_lim;
    bit       m_hitq;
    bit [7:0] m_lfsr;

    function automatic int pick_hole(bit [7:0] r, int prev);
        int v;
        v = int'(r) % NH;
        if (v == prev) v = (v + 1) % NH;
        return v;
    endfunction

    function automatic int next_lim(int lim);
        int l;
        l = lim - UP / 8;
        return (l < UP / 4) ? UP / 4 : l;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= P_IDLE; m_left <= 0; m_score <= 0; m_miss <= 0;
            m_idx <= 0; m_lim <= UP; m_hitq <= 1'b0; m_lfsr <= 8'hA5;
        end else begin
            m_hitq <= hit;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            case (m_ph)
                P_IDLE, P_OVER: if (start) begin
                    m_ph <= P_GAP; m_left <= GAP; m_score <= 0; m_miss <= 0; m_lim <= UP;
                end
                P_GAP: if (m_left == 1) begin
                    m_ph <= P_UP; m_left <= m_lim; m_idx <= pick_hole(m_lfsr, m_idx);
                end else m_left <= m_left - 1;
                P_UP: if (hit && !m_hitq && int'(hammer_pos) == m_idx) begin
                    m_ph <= P_HIT; m_left <= 8;
                    if (m_score < SMAX) begin
                        m_score <= m_score + 1;
`ifdef SPEEDUP_EN
                        if ((m_score + 1) % 4 == 0) m_lim <= next_lim(m_lim);
`endif
                    end
                end else if (m_left == 1) begin
                    m_miss <= m_miss + 1; m_left <= GAP;
                    m_ph <= (m_miss + 1 == MAXM) ? P_OVER : P_GAP;
                end else m_left <= m_left - 1;
                P_HIT: if (m_left == 1) begin
                    m_ph <= P_GAP; m_left <= GAP;
                end else m_left <= m_left - 1;
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    function automatic logic [13:0] exp_vec();
        return {m_ph == P_UP, 4'(m_idx), m_ph == P_HIT, SW'(m_score), 4'(m_miss), m_ph == P_OVER};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_up();
        int n = 0;
        while (!mole_active && n < 40) begin
            step();
            n++;
        end
        if (!mole_active) begin
            vecs++; errs++;
            $display("FAIL wait_up: mole_active=%b after %0d cycles, required 1", mole_active, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        vecs++;
        if ({mole_active, mole_idx, hit_flash, score, misses, game_over} !== 14'd0) begin
            errs++;
            $display("FAIL reset_values: got %h required 0",
                     {mole_active, mole_idx, hit_flash, score, misses, game_over});
        end
        rst = 1'b0;
        repeat (4) step();
        vecs++;
        if (mole_active !== 1'b0 || game_over !== 1'b0) begin
            errs++;
            $display("FAIL idle_hold: active=%b over=%b required 0 0", mole_active, game_over);
        end
    endtask

    task automatic test_start_timing();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            vecs++;
            if (mole_active !== (k == 5)) begin
                errs++;
                $display("FAIL start_timing k=%0d: active=%b required %b", k, mole_active, k == 5);
            end
        end
        vecs++;
        if (mole_idx !== 4'(m_idx) || mole_idx >= 4'(NH)) begin
            errs++;
            $display("FAIL first_mole: idx=%0d required %0d", mole_idx, m_idx);
        end
    endtask

    task automatic test_hit_match();
        int flash = 0;
        hammer_pos = 4'(m_idx);
        hit = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 3) hit = 1'b0;
            if (hit_flash) flash++;
            vecs++;
            if (score !== SW'(1)) begin
                errs++;
                $display("FAIL hit_score i=%0d: score=%0d required 1", i, score);
            end
        end
        vecs++;
        if (flash != 8) begin
            errs++;
            $display("FAIL flash_len: %0d cycles required 8", flash);
        end
        vecs++;
        if (hit_flash !== 1'b0 || mole_active !== 1'b0 || game_over !== 1'b0) begin
            errs++;
            $display("FAIL hit_to_gap: flash=%b active=%b over=%b required 0 0 0",
                     hit_flash, mole_active, game_over);
        end
    endtask

    task automatic test_wrong_hole();
        int cnt = 0;
        wait_up();
        hammer_pos = 4'((m_idx + 1) % NH);
        hit = 1'b1;
        for (int i = 0; i < 30 && mole_active; i++) begin
            cnt++;
            step();
            if (i == 1) hit = 1'b0;
        end
        hit = 1'b0;
        vecs++;
        if (cnt != UP || misses !== 4'd1 || score !== SW'(1)) begin
            errs++;
            $display("FAIL wrong_hole: up=%0d misses=%0d score=%0d required %0d 1 1",
                     cnt, misses, score, UP);
        end
    endtask

    task automatic test_hit_timeout();
        wait_up();
        hammer_pos = 4'(m_idx);
        hit = 1'b0;
        repeat (UP - 1) step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        vecs++;
        if (score !== SW'(2) || misses !== 4'd1 || hit_flash !== 1'b1) begin
            errs++;
            $display("FAIL hit_vs_timeout: score=%0d misses=%0d flash=%b required 2 1 1",
                     score, misses, hit_flash);
        end
    endtask

    task automatic test_saturation();
        int e = 2;
        for (int n = 0; n < 7; n++) begin
            wait_up();
            hammer_pos = 4'(m_idx);
            hit = 1'b1;
            step();
            hit = 1'b0;
            e = (e < SMAX) ? e + 1 : SMAX;
            vecs++;
            if (score !== SW'(e)) begin
                errs++;
                $display("FAIL saturate n=%0d: score=%0d required %0d", n, score, e);
            end
        end
    endtask

    task automatic test_up_length();
        int cnt = 0;
        int want = UP;
`ifdef SPEEDUP_EN
        want = next_lim(UP);
`endif
        wait_up();
        for (int i = 0; i < 30 && mole_active; i++) begin
            cnt++;
            step();
        end
        vecs++;
        if (cnt != want || misses !== 4'd2) begin
            errs++;
            $display("FAIL up_length: up=%0d misses=%0d required %0d 2", cnt, misses, want);
        end
    endtask

    task automatic test_distinct();
        int prev = m_idx;
        for (int n = 0; n < 50; n++) begin
            wait_up();
            vecs++;
            if (mole_idx >= 4'(NH) || int'(mole_idx) == prev || mole_idx !== 4'(m_idx)) begin
                errs++;
                $display("FAIL distinct n=%0d: idx=%0d prev=%0d required %0d",
                         n, mole_idx, prev, m_idx);
            end
            prev = m_idx;
            hammer_pos = 4'(m_idx);
            hit = 1'b1;
            step();
            hit = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        wait_up();
        rst = 1'b1;
        #1;
        vecs++;
        if ({mole_active, mole_idx, hit_flash, score, misses, game_over} !== 14'd0) begin
            errs++;
            $display("FAIL reset_mid: got %h required 0",
                     {mole_active, mole_idx, hit_flash, score, misses, game_over});
        end
        step();
        rst = 1'b0;
        repeat (8) step();
        vecs++;
        if (mole_active !== 1'b0 || hit_flash !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle: active=%b flash=%b required 0 0", mole_active, hit_flash);
        end
    endtask

    task automatic test_game_over();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 80 && !game_over; i++) step();
        vecs++;
        if (game_over !== 1'b1 || misses !== 4'(MAXM) || score !== '0) begin
            errs++;
            $display("FAIL game_over: over=%b misses=%0d score=%0d required 1 %0d 0",
                     game_over, misses, score, MAXM);
        end
        for (int i = 0; i < 100; i++) begin
            hit = 1'($urandom_range(0, 1));
            hammer_pos = 4'($urandom_range(0, 15));
            step();
            vecs++;
            if (game_over !== 1'b1 || misses !== 4'(MAXM) || mole_active !== 1'b0) begin
                errs++;
                $display("FAIL over_hold i=%0d: over=%b misses=%0d active=%b",
                         i, game_over, misses, mole_active);
            end
        end
        hit = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        vecs++;
        if (game_over !== 1'b0 || misses !== 4'd0 || score !== '0 || mole_active !== 1'b0) begin
            errs++;
            $display("FAIL restart: over=%b misses=%0d score=%0d active=%b required 0 0 0 0",
                     game_over, misses, score, mole_active);
        end
    endtask

    task automatic test_random();
        logic [13:0] got;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 49) == 0);
            hit = ($urandom_range(0, 2) == 0);
            hammer_pos = ($urandom_range(0, 1) == 0) ? 4'(m_idx) : 4'($urandom_range(0, 15));
            step();
            got = {mole_active, mole_idx, hit_flash, score, misses, game_over};
            vecs++;
            if (got !== exp_vec()) begin
                errs++;
                $display("FAIL random i=%0d: got %h required %h", i, got, exp_vec());
            end
        end
        start = 1'b0;
        hit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_timing();
        test_hit_match();
        test_wrong_hole();
        test_hit_timeout();
        test_saturation();
        test_up_length();
        test_distinct();
        test_reset_mid();
        test_game_over();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
